// File: rtl/register_mode_pipe.sv
// Operand register file with CONST/BYPASS/DELAY/ACCUM modes, config write and read-back of any stage.
// Outputs are combinational from state and inputs (zero latency); no backpressure, DELAY/ACCUM advance on clk_en.
module register_mode_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] const_,
  input  logic [WIDTH-1:0] value,
  input  logic             clk_en,
  input  logic [DW-1:0]    delay,
  input  logic             config_we,
  input  logic [AW-1:0]    config_addr,
  input  logic [WIDTH-1:0] config_data,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic             valid
);

  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_DELAY  = 2'd2,
    MODE_ACCUM  = 2'd3
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DW-1:0]    fill_q, fill_d;
  logic [1:0]       prev_mode_q, prev_mode_d;
  logic [DW-1:0]    d_eff;
  logic [AW-1:0]    tap;
  logic             addr_ok;

  assign mode_sel = mode_e'(mode);

  // Clamp requested delay into 1..DEPTH.
  always_comb begin
    d_eff = delay;
    if (delay == '0) begin
      d_eff = DW'(1);
    end else if (int'(delay) > DEPTH) begin
      d_eff = DW'(DEPTH);
    end
  end

  assign tap     = AW'(d_eff - DW'(1));
  assign addr_ok = int'(config_addr) < DEPTH;

  always_comb begin
    stage_d     = stage_q;
    fill_d      = fill_q;
    prev_mode_d = mode;
    if (config_we) begin
      if (addr_ok) begin
        stage_d[config_addr] = config_data;
      end
    end else begin
      if (mode != prev_mode_q) begin
        fill_d = '0;
      end
      case (mode_sel)
        MODE_DELAY: begin
          if (clk_en) begin
            stage_d[0] = value;
            for (int i = 1; i < DEPTH; i++) begin
              stage_d[i] = stage_q[i-1];
            end
            if (int'(fill_d) < DEPTH) begin
              fill_d = fill_d + DW'(1);
            end
          end
        end
        MODE_ACCUM: begin
          if (clk_en) begin
            stage_d[0] = stage_q[0] + value;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      fill_q      <= '0;
      prev_mode_q <= '0;
    end else begin
      stage_q     <= stage_d;
      fill_q      <= fill_d;
      prev_mode_q <= prev_mode_d;
    end
  end

  always_comb begin
    O0    = stage_q[0];
    valid = 1'b1;
    case (mode_sel)
      MODE_CONST:  O0 = const_;
      MODE_BYPASS: O0 = value;
      MODE_DELAY: begin
        O0    = stage_q[tap];
        valid = (fill_q >= d_eff);
      end
      default:     O0 = stage_q[0];
    endcase
  end

  assign O1 = addr_ok ? stage_q[config_addr] : '0;

endmodule

// File: doc/register_mode_pipe.md
# register_mode_pipe

Parametrised successor to the single-register mode block: a WIDTH-bit datapath register file of DEPTH stages with four run-time modes (constant, bypass, programmable delay line, accumulator). It sits on a PE/tile operand input, between the interconnect and the ALU. It provides configuration-bus write and read-back of any stage, and a valid flag that tracks delay-line fill.

## Interface
Parameters:
- WIDTH, 16, datapath and stage width in bits (≥1)
- DEPTH, 4, number of pipeline stages (≥2); AW = $clog2(DEPTH), DW = $clog2(DEPTH+1)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- mode  in  2  0=CONST, 1=BYPASS, 2=DELAY, 3=ACCUM
- const_  in  WIDTH  constant operand for CONST mode
- value  in  WIDTH  streaming operand
- clk_en  in  1  advance enable for DELAY/ACCUM
- delay  in  DW  selected delay length for DELAY mode
- config_we  in  1  config write strobe
- config_addr  in  AW  stage index for config write/read
- config_data  in  WIDTH  config write data
- O0  out  WIDTH  datapath output
- O1  out  WIDTH  read-back of stage[config_addr]
- valid  out  1  O0 carries a stream value (see Operation)

## Operation
- State: stage[0..DEPTH-1] (WIDTH each), fill counter fill (DW bits, saturating at DEPTH), prev_mode (2 bits).
- Effective delay d = 1 if delay==0; DEPTH if delay>DEPTH; else delay.
- Priority per edge: RESET > config_we > mode action.
- RESET: all stages 0, fill 0, prev_mode 0.
- config_we=1: stage[config_addr] <= config_data; no shift/accumulate that cycle; fill unchanged. config_addr ≥ DEPTH (non-power-of-2 DEPTH) → write ignored.
- CONST: O0 = const_; stages hold; valid = 1.
- BYPASS: O0 = value; stages hold; valid = 1.
- DELAY: when clk_en, stage[0] <= value, stage[i] <= stage[i-1]; fill <= min(fill+1, DEPTH). O0 = stage[d-1]. valid = (fill ≥ d).
- ACCUM: when clk_en, stage[0] <= stage[0] + value modulo 2^WIDTH (carry discarded); other stages hold; fill held. O0 = stage[0]; valid = 1.
- clk_en=0 in DELAY/ACCUM: all state holds.
- Mode change: any edge where mode != prev_mode sets fill <= 0 (stages untouched), unless the edge is a RESET or config write that also applies; prev_mode <= mode every non-reset edge. Shift in the same cycle as a mode change into DELAY still occurs, fill = 1 after.
- O1 = stage[config_addr] combinationally, independent of mode; 0 when config_addr ≥ DEPTH.

## Timing
- O0, O1, valid are combinational from current state and inputs; no output register.
- CONST/BYPASS: zero-cycle latency const_/value → O0.
- DELAY: value sampled at edge k with clk_en appears on O0 after d enabled edges (d=1 → visible after next edge).
- ACCUM: sum visible on O0 one cycle after enabled edge.
- Config write visible on O1 and (if selected) O0 the cycle after the write edge.
- Reset values: O0 = 0 in DELAY/ACCUM, const_/value in CONST/BYPASS; O1 = 0; valid = 0 in DELAY, 1 otherwise.
- Changing delay mid-stream changes tap immediately; valid recomputed against current fill (may drop).

## Test plan
- WIDTH=16, DEPTH=4, reset then mode=2, delay=3, clk_en=1, value=1,2,3,4,… per cycle → O0 = 1 on cycle after 3rd edge, then 2,3,…; valid low for first 2 post-reset cycles, high from 3rd edge on.
- DELAY, delay=0 and delay=7 → behave as d=1 and d=4 respectively; clk_en toggled 1,0,1 → output and fill freeze during 0.
- ACCUM, value=0xFFFF twice from reset → O0 = 0xFFFF then 0xFFFE (wrap); clk_en=0 holds.
- config_we=1, addr=2, data=0xA5A5 while DELAY, clk_en=1 → no shift that cycle, O1(addr=2)=0xA5A5, next enabled shifts move it to stage 3 and O0 at d=4.
- Mode 2→0→2 mid-stream → O0=const_ in CONST, on return valid=0 until d new enabled edges; stage contents retained.
- RESET asserted mid-DELAY with config_we=1 → all stages 0, fill 0, valid=0 next cycle; write discarded.
